// File: rtl/led_breath_pwm_pkg.sv
// ============================================================================
// led_breath_pwm_pkg : mode codes and breathing FSM state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package led_breath_pwm_pkg;

    localparam logic [1:0] MODE_PASS    = 2'b00;
    localparam logic [1:0] MODE_FIXED   = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;

    typedef enum logic [2:0] {
        ST_STATIC  = 3'd0,
        ST_RISE    = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_FALL    = 3'd3,
        ST_HOLD_LO = 3'd4
    } breath_state_t;

endpackage

`default_nettype wire

// File: rtl/led_breath_pwm_pwm_core.sv
// ============================================================================
// led_breath_pwm_pwm_core : PWM counter, duty compare, period-aligned duty reg
// Rev 1.0
// ============================================================================
`default_nettype none

module led_breath_pwm_pwm_core
    import led_breath_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty_nxt,
    input  logic                duty_we,
    output logic                period_end,
    output logic                pwm_on,
    output logic [PWM_BITS-1:0] duty_cur
);

    localparam logic [PWM_BITS-1:0] c_max  = '1;
    localparam logic [PWM_BITS-1:0] c_last = c_max - 1'b1;

    logic [PWM_BITS-1:0] r_cnt;

    // Period is MAX cycles so that duty MAX means on for every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (period_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_cur <= '0;
        end else if (period_end && duty_we) begin
            duty_cur <= duty_nxt;
        end
    end

    assign period_end = (r_cnt == c_last);
    assign pwm_on     = (r_cnt < duty_cur);

endmodule

`default_nettype wire

// File: rtl/led_breath_pwm.sv
// ============================================================================
// led_breath_pwm : LED PWM dimmer with pass-through, fixed and breathing modes
// Rev 1.0
// ============================================================================
`default_nettype none

module led_breath_pwm
    import led_breath_pwm_pkg::*;
#(
    parameter int LED_W        = 4,
    parameter int PWM_BITS     = 8,
    parameter int STEP_PERIODS = 4,
    parameter int HOLD_STEPS   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LED_W-1:0]    led_in,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty_in,
    input  logic                duty_load,
    output logic [LED_W-1:0]    led_out,
    output logic [PWM_BITS-1:0] duty_cur,
    output logic                breathing
);

    localparam int c_step_w = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int c_hold_w = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [c_step_w-1:0] c_step_last = c_step_w'(STEP_PERIODS - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_STEPS - 1);
    localparam logic [PWM_BITS-1:0] c_max       = '1;
    localparam logic [PWM_BITS-1:0] c_max_m1    = c_max - 1'b1;

    breath_state_t       r_state;
    logic [c_step_w-1:0] r_step_cnt;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [PWM_BITS-1:0] r_duty_pend;
    logic                r_pend_vld;

    logic                w_period_end;
    logic                w_pwm_on;
    logic                w_in_breathe;
    logic                w_step_tick;
    logic [PWM_BITS-1:0] w_duty_nxt;
    logic                w_duty_we;

    assign w_in_breathe = (r_state != ST_STATIC) && (mode == MODE_BREATHE);
    assign w_step_tick  = w_period_end && (r_step_cnt == c_step_last) && w_in_breathe;

    always_comb begin
        w_duty_nxt = r_duty_pend;
        w_duty_we  = 1'b0;
        if (w_in_breathe) begin
            if (w_step_tick && r_state == ST_RISE && duty_cur != c_max) begin
                w_duty_nxt = duty_cur + 1'b1;
                w_duty_we  = 1'b1;
            end else if (w_step_tick && r_state == ST_FALL && duty_cur != '0) begin
                w_duty_nxt = duty_cur - 1'b1;
                w_duty_we  = 1'b1;
            end
        end else if (r_state == ST_STATIC && mode == MODE_FIXED && r_pend_vld) begin
            w_duty_we = 1'b1;
        end
    end

    led_breath_pwm_pwm_core #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_core (
        .clk        (clk),
        .rst        (rst),
        .duty_nxt   (w_duty_nxt),
        .duty_we    (w_duty_we),
        .period_end (w_period_end),
        .pwm_on     (w_pwm_on),
        .duty_cur   (duty_cur)
    );

    // A load coinciding with period_end wins over clearing, so it lands one period later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_pend <= '0;
            r_pend_vld  <= 1'b0;
        end else if (mode == MODE_FIXED && duty_load) begin
            r_duty_pend <= duty_in;
            r_pend_vld  <= 1'b1;
        end else if (w_period_end && w_duty_we && r_state == ST_STATIC) begin
            r_pend_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_STATIC;
            breathing  <= 1'b0;
            r_step_cnt <= '0;
            r_hold_cnt <= '0;
        end else if (r_state == ST_STATIC) begin
            if (mode == MODE_BREATHE) begin
                r_state    <= ST_RISE;
                breathing  <= 1'b1;
                r_step_cnt <= '0;
                r_hold_cnt <= '0;
            end
        end else if (mode != MODE_BREATHE) begin
            r_state   <= ST_STATIC;
            breathing <= 1'b0;
        end else begin
            if (w_period_end) begin
                r_step_cnt <= (r_step_cnt == c_step_last) ? '0 : r_step_cnt + 1'b1;
            end
            if (w_step_tick) begin
                case (r_state)
                    ST_RISE: begin
                        if (duty_cur == c_max || duty_cur == c_max_m1) begin
                            r_state    <= ST_HOLD_HI;
                            r_hold_cnt <= '0;
                        end
                    end
                    ST_HOLD_HI: begin
                        if (r_hold_cnt == c_hold_last) begin
                            r_state    <= ST_FALL;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    ST_FALL: begin
                        if (duty_cur <= {{(PWM_BITS-1){1'b0}}, 1'b1}) begin
                            r_state    <= ST_HOLD_LO;
                            r_hold_cnt <= '0;
                        end
                    end
                    ST_HOLD_LO: begin
                        if (r_hold_cnt == c_hold_last) begin
                            r_state    <= ST_RISE;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= ST_STATIC;
                        breathing <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out <= '0;
        end else if (mode == MODE_FIXED || mode == MODE_BREATHE) begin
            led_out <= led_in & {LED_W{w_pwm_on}};
        end else begin
            led_out <= led_in;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_led_breath_pwm.sv
// ============================================================================
// tb_led_breath_pwm : scoreboard bench, 8-bit instance plus a 4-bit instance
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_led_breath_pwm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] led_in = 4'b1010;
    logic [1:0] mode8 = 2'b00;
    logic [1:0] mode4 = 2'b00;
    logic [7:0] duty_in = 8'd0;
    logic       duty_load = 1'b0;
    logic [3:0] duty_in4 = 4'd0;
    logic       duty_load4 = 1'b0;

    logic [3:0] led8, led4;
    logic [7:0] duty8;
    logic [3:0] duty4;
    logic       br8, br4;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct { string tag; int exp; } sb_t;
    typedef struct { int val; int gap; } tr_t;
    sb_t sb_q[$];
    tr_t tr4_q[$];

    always #10 clk = ~clk;

    led_breath_pwm #(.LED_W(4), .PWM_BITS(8), .STEP_PERIODS(2), .HOLD_STEPS(3)) dut8 (
        .clk(clk), .rst(rst), .led_in(led_in), .mode(mode8), .duty_in(duty_in),
        .duty_load(duty_load), .led_out(led8), .duty_cur(duty8), .breathing(br8)
    );

    led_breath_pwm #(.LED_W(4), .PWM_BITS(4), .STEP_PERIODS(2), .HOLD_STEPS(3)) dut4 (
        .clk(clk), .rst(rst), .led_in(led_in), .mode(mode4), .duty_in(duty_in4),
        .duty_load(duty_load4), .led_out(led4), .duty_cur(duty4), .breathing(br4)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_chk(input int obs);
        sb_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", sb_q.size(), 1);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, obs, e.exp);
        end
    endtask

    // Posedges since reset release; pwm_cnt equals cyc modulo the period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin : mon8
        logic [7:0] prev8;
        prev8 = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst && duty8 != prev8) check_val("phase8", cyc % 255, 0);
            prev8 = duty8;
        end
    end

    initial begin : mon4
        logic [3:0] prev4;
        int         gap4;
        tr_t        e;
        prev4 = 4'd0;
        gap4  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                gap4 = 0;
            end else begin
                gap4++;
                if (duty4 != prev4) begin
                    check_val("phase4", cyc % 15, 0);
                    if (tr4_q.size() > 0) begin
                        e = tr4_q.pop_front();
                        check_val("breathe4_val", duty4, e.val);
                        if (e.gap > 0) check_val("breathe4_gap", gap4, e.gap);
                    end
                    gap4 = 0;
                end
            end
            prev4 = duty4;
        end
    end

    task automatic wait_change8(input int limit, output int gap);
        logic [7:0] start;
        start = duty8;
        gap   = 0;
        while (duty8 == start && gap < limit) begin
            @(negedge clk);
            gap++;
        end
        check_val("wait8_changed", int'(duty8 != start), 1);
    endtask

    task automatic wait_val4(input int val, input int limit);
        int n;
        n = 0;
        while (int'(duty4) != val && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_val("wait4_reached", duty4, val);
    endtask

    task automatic load8(input int d);
        duty_in   = 8'(d);
        duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
    endtask

    task automatic measure8(output int on, output int bad);
        on  = 0;
        bad = 0;
        repeat (255) begin
            @(negedge clk);
            if (led8 == led_in)    on++;
            else if (led8 != 4'd0) bad++;
        end
    endtask

    initial begin : watchdog
        #(20 * 60000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int g, on, bad;

        // Reset behaviour and pass-through latency
        repeat (10) @(negedge clk);
        push("rst_led8", 0); push("rst_duty8", 0); push("rst_br8", 0); push("rst_led4", 0);
        pop_chk(led8); pop_chk(duty8); pop_chk(br8); pop_chk(led4);
        rst = 1'b0;
        push("pass_led8", 4'b1010);
        @(negedge clk);
        pop_chk(led8);

        // Fixed duty 64, two loads in one period: last wins
        mode8 = 2'b01;
        duty_in = 8'd30; duty_load = 1'b1;
        @(negedge clk);
        duty_in = 8'd64;
        @(negedge clk);
        duty_load = 1'b0;
        wait_change8(600, g);
        push("fix_last_wins", 64); pop_chk(duty8);
        push("fix64_on", 64); push("fix64_bad", 0);
        measure8(on, bad);
        pop_chk(on); pop_chk(bad);

        // Duty extremes
        load8(0);
        wait_change8(600, g);
        push("fix0_duty", 0); push("fix0_on", 0);
        pop_chk(duty8);
        measure8(on, bad);
        pop_chk(on);
        load8(255);
        wait_change8(600, g);
        push("fix255_duty", 255); push("fix255_on", 255); push("fix255_bad", 0);
        pop_chk(duty8);
        measure8(on, bad);
        pop_chk(on); pop_chk(bad);

        // Breathing from duty 0; 4-bit instance runs a full trajectory in parallel
        load8(0);
        wait_change8(600, g);
        push("br_start_duty", 0); pop_chk(duty8);
        for (int v = 1; v <= 15; v++) tr4_q.push_back('{val: v, gap: (v == 1) ? 0 : 30});
        for (int v = 14; v >= 0; v--) tr4_q.push_back('{val: v, gap: (v == 14) ? 120 : 30});
        tr4_q.push_back('{val: 1, gap: 120});
        tr4_q.push_back('{val: 2, gap: 30});
        mode8 = 2'b10;
        mode4 = 2'b10;
        push("br_on8", 1);
        @(negedge clk);
        pop_chk(br8);
        wait_change8(1200, g);
        push("br_first", 1); pop_chk(duty8);
        for (int k = 2; k <= 3; k++) begin
            wait_change8(600, g);
            push("br_step_gap", 510); push("br_step_val", k);
            pop_chk(g); pop_chk(duty8);
        end

        // Exit breathing mid-RISE at duty 100
        mode8 = 2'b01;
        load8(98);
        wait_change8(600, g);
        push("rise98", 98); pop_chk(duty8);
        mode8 = 2'b10;
        wait_change8(1200, g);
        wait_change8(600, g);
        push("rise100", 100); pop_chk(duty8);
        mode8  = 2'b00;
        led_in = 4'b0110;
        push("exit_br", 0); push("exit_led", 4'b0110); push("exit_duty", 100);
        @(negedge clk);
        pop_chk(br8); pop_chk(led8); pop_chk(duty8);
        repeat (600) @(negedge clk);
        push("exit_duty_kept", 100); pop_chk(duty8);

        // Async reset mid-FALL on the 4-bit instance
        wait_val4(15, 2500);
        wait_val4(5, 1200);
        push("arst_led8", 0); push("arst_duty8", 0); push("arst_duty4", 0);
        push("arst_br4", 0); push("arst_led4", 0);
        #3 rst = 1'b1;
        #1;
        pop_chk(led8); pop_chk(duty8); pop_chk(duty4); pop_chk(br4); pop_chk(led4);
        @(negedge clk);
        #2 rst = 1'b0;
        push("post_rst_static", 0);
        pop_chk(br4);
        repeat (29) @(negedge clk);
        push("post_rst_duty0", 0); push("post_rst_br", 1);
        pop_chk(duty4); pop_chk(br4);
        @(negedge clk);
        push("post_rst_duty1", 1); pop_chk(duty4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
